// File: rtl/gpr_scoreboard.sv
// General-purpose register file with a per-register pending-write scoreboard.
// Two combinational read ports with busy flags, one writeback port with overflow suppression.
module gpr_scoreboard #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned CNT_W    = 2,
    parameter int unsigned FLAG_REG = 30,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] RdAddr1,
    input  logic [ADDR_W-1:0] RdAddr2,
    output logic [DATA_W-1:0] RdData1,
    output logic [DATA_W-1:0] RdData2,
    output logic              RdBusy1,
    output logic              RdBusy2,
    input  logic              IssueEn,
    input  logic [ADDR_W-1:0] IssueAddr,
    output logic              IssueFull,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic              OFWrEn,
    input  logic              OFFlag,
    output logic              SbErr
);

    localparam int unsigned NREG     = 1 << ADDR_W;
    localparam int unsigned NPORT    = 2;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] FLAG_IDX = ADDR_W'(FLAG_REG);
    localparam bit                FLAG_OK  = (FLAG_REG != 0) && (FLAG_REG < NREG);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [CNT_W-1:0]  cnt_q  [NREG];
    logic [CNT_W-1:0]  cnt_d  [NREG];
    logic              sb_err_q;
    logic              sb_err_d;

    logic              wr_live_c;
    logic              commit_c;
    logic              flag_wr_c;

    // A live writeback retires one pending write; it commits data unless overflow suppresses it.
    assign wr_live_c = WrEn && (WrAddr != '0);
    assign commit_c  = wr_live_c && !(OFWrEn && OFFlag);
    assign flag_wr_c = OFWrEn && FLAG_OK;

    // Full only when no same-cycle retire to the same register frees a slot.
    assign IssueFull = IssueEn && (IssueAddr != '0) && (cnt_q[IssueAddr] == CNT_MAX)
                       && !(wr_live_c && (WrAddr == IssueAddr));

    always_comb begin
        regs_d   = regs_q;
        cnt_d    = cnt_q;
        sb_err_d = sb_err_q;

        if (commit_c) begin
            regs_d[WrAddr] = WrData;
        end
        if (flag_wr_c) begin
            regs_d[FLAG_IDX][0] = OFFlag;
        end

        for (int i = 1; i < NREG; i++) begin
            logic iss;
            logic ret;
            iss = IssueEn && (IssueAddr == ADDR_W'(i));
            ret = wr_live_c && (WrAddr == ADDR_W'(i));
            if (iss && ret) begin
                cnt_d[i] = cnt_q[i];
            end else if (iss) begin
                if (cnt_q[i] != CNT_MAX) begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else if (ret) begin
                if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - CNT_ONE;
                end else begin
                    sb_err_d = 1'b1;
                end
            end
        end

        regs_d[0] = '0;
        cnt_d[0]  = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            sb_err_q <= sb_err_d;
        end
    end

    assign SbErr = sb_err_q;

    logic [ADDR_W-1:0] rd_addr   [NPORT];
    logic [DATA_W-1:0] rd_data_c [NPORT];
    logic              rd_busy_c [NPORT];

    assign rd_addr[0] = RdAddr1;
    assign rd_addr[1] = RdAddr2;

    // Read ports: stored value, optionally overlaid with the same-cycle writeback.
    for (genvar p = 0; p < NPORT; p++) begin : g_rd
        always_comb begin
            rd_data_c[p] = regs_q[rd_addr[p]];
            rd_busy_c[p] = (cnt_q[rd_addr[p]] != '0);
            if (BYPASS) begin
                if (commit_c && (rd_addr[p] == WrAddr)) begin
                    rd_data_c[p] = WrData;
                end
                if (flag_wr_c && (rd_addr[p] == FLAG_IDX)) begin
                    rd_data_c[p][0] = OFFlag;
                end
                if (wr_live_c && (rd_addr[p] == WrAddr)) begin
                    rd_busy_c[p] = (cnt_q[rd_addr[p]] > CNT_ONE);
                end
            end
            if (rd_addr[p] == '0) begin
                rd_data_c[p] = '0;
                rd_busy_c[p] = 1'b0;
            end
        end
    end

    assign RdData1 = rd_data_c[0];
    assign RdData2 = rd_data_c[1];
    assign RdBusy1 = rd_busy_c[0];
    assign RdBusy2 = rd_busy_c[1];

endmodule

// File: tb/tb_gpr_scoreboard.sv
// Directed bench for gpr_scoreboard: one instance with bypass, one without, driven in lockstep.
module tb_gpr_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  RdAddr1, RdAddr2, IssueAddr, WrAddr;
    logic        IssueEn, WrEn, OFWrEn, OFFlag;
    logic [31:0] WrData;

    logic [31:0] b_rd1, b_rd2, n_rd1, n_rd2;
    logic        b_bz1, b_bz2, n_bz1, n_bz2;
    logic        b_full, n_full, b_err, n_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gpr_scoreboard #(.BYPASS(1'b1)) u_byp (
        .clk(clk), .rst(rst), .RdAddr1(RdAddr1), .RdAddr2(RdAddr2),
        .RdData1(b_rd1), .RdData2(b_rd2), .RdBusy1(b_bz1), .RdBusy2(b_bz2),
        .IssueEn(IssueEn), .IssueAddr(IssueAddr), .IssueFull(b_full),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .OFWrEn(OFWrEn), .OFFlag(OFFlag), .SbErr(b_err)
    );

    gpr_scoreboard #(.BYPASS(1'b0)) u_nob (
        .clk(clk), .rst(rst), .RdAddr1(RdAddr1), .RdAddr2(RdAddr2),
        .RdData1(n_rd1), .RdData2(n_rd2), .RdBusy1(n_bz1), .RdBusy2(n_bz2),
        .IssueEn(IssueEn), .IssueAddr(IssueAddr), .IssueFull(n_full),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .OFWrEn(OFWrEn), .OFFlag(OFFlag), .SbErr(n_err)
    );

    task automatic idle();
        IssueEn = 1'b0; IssueAddr = '0;
        WrEn = 1'b0; WrAddr = '0; WrData = '0;
        OFWrEn = 1'b0; OFFlag = 1'b0;
    endtask

    // Advance to just after the next rising edge, then drop all enables.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue(input logic [4:0] a);
        IssueEn = 1'b1; IssueAddr = a;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        WrEn = 1'b1; WrAddr = a; WrData = d;
    endtask

    task automatic test_reset();
        wr(5'd5, 32'h11); issue(5'd5);
        step();
        issue(5'd5);
        step();
        wr(5'd6, 32'h0);
        step();
        RdAddr1 = 5'd5;
        #1;
        n_checks++;
        if (b_err !== 1'b1) begin n_fail++; $display("FAIL pre_reset_sberr: got %b want 1", b_err); end
        n_checks++;
        if (b_rd1 !== 32'h11 || b_bz1 !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_reg5: got %h busy %b want 00000011 busy 1", b_rd1, b_bz1);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (b_rd1 !== 32'h0 || b_bz1 !== 1'b0 || n_rd1 !== 32'h0 || n_bz1 !== 1'b0) begin
            n_fail++; $display("FAIL reset_read: got %h/%b %h/%b want 0/0", b_rd1, b_bz1, n_rd1, n_bz1);
        end
        n_checks++;
        if (b_err !== 1'b0 || n_err !== 1'b0 || b_full !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: sberr %b %b full %b want 0", b_err, n_err, b_full);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_scoreboard();
        RdAddr1 = 5'd3;
        for (int k = 0; k < 3; k++) begin
            issue(5'd3);
            step();
        end
        #1;
        n_checks++;
        if (b_bz1 !== 1'b1 || n_bz1 !== 1'b1) begin
            n_fail++; $display("FAIL sb_busy_after_3: got %b %b want 1", b_bz1, n_bz1);
        end
        issue(5'd3);
        #1;
        n_checks++;
        if (b_full !== 1'b1 || n_full !== 1'b1) begin
            n_fail++; $display("FAIL sb_full_4th: got %b %b want 1", b_full, n_full);
        end
        step();
        for (int k = 0; k < 2; k++) begin
            wr(5'd3, 32'h30 + 32'(k));
            step();
        end
        #1;
        n_checks++;
        if (b_bz1 !== 1'b1 || n_bz1 !== 1'b1) begin
            n_fail++; $display("FAIL sb_busy_after_2_retires: got %b %b want 1", b_bz1, n_bz1);
        end
        wr(5'd3, 32'h33);
        #1;
        n_checks++;
        if (b_bz1 !== 1'b0 || n_bz1 !== 1'b1) begin
            n_fail++; $display("FAIL sb_last_retire_busy: byp %b nob %b want 0 1", b_bz1, n_bz1);
        end
        step();
        #1;
        n_checks++;
        if (b_bz1 !== 1'b0 || n_bz1 !== 1'b0 || b_err !== 1'b0) begin
            n_fail++; $display("FAIL sb_drained: busy %b %b sberr %b want 0 0 0", b_bz1, n_bz1, b_err);
        end
    endtask

    task automatic test_simultaneous();
        RdAddr2 = 5'd4;
        for (int k = 0; k < 3; k++) begin
            issue(5'd4);
            step();
        end
        issue(5'd4); wr(5'd4, 32'h44);
        #1;
        n_checks++;
        if (b_full !== 1'b0 || n_full !== 1'b0) begin
            n_fail++; $display("FAIL sim_issue_retire_full: got %b %b want 0", b_full, n_full);
        end
        step();
        issue(5'd4);
        #1;
        n_checks++;
        if (b_full !== 1'b1 || b_bz2 !== 1'b1 || b_err !== 1'b0) begin
            n_fail++; $display("FAIL sim_cnt_kept_at_max: full %b busy %b sberr %b want 1 1 0", b_full, b_bz2, b_err);
        end
        step();
    endtask

    task automatic test_sberr();
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        idle();
        wr(5'd6, 32'h66);
        #1;
        n_checks++;
        if (b_err !== 1'b0) begin n_fail++; $display("FAIL sberr_clean: got %b want 0", b_err); end
        step();
        step();
        step();
        #1;
        n_checks++;
        if (b_err !== 1'b1 || n_err !== 1'b1) begin
            n_fail++; $display("FAIL sberr_sticky: got %b %b want 1", b_err, n_err);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (b_err !== 1'b0) begin n_fail++; $display("FAIL sberr_cleared: got %b want 0", b_err); end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_write();
        RdAddr1 = 5'd5;
        wr(5'd5, 32'hDEADBEEF);
        step();
        #1;
        n_checks++;
        if (b_rd1 !== 32'hDEADBEEF || n_rd1 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL write_reg5: got %h %h want deadbeef", b_rd1, n_rd1);
        end
        RdAddr1 = 5'd0;
        wr(5'd0, 32'h55);
        #1;
        n_checks++;
        if (b_rd1 !== 32'h0) begin n_fail++; $display("FAIL write_reg0_bypass: got %h want 0", b_rd1); end
        step();
        #1;
        n_checks++;
        if (b_rd1 !== 32'h0 || n_rd1 !== 32'h0 || b_bz1 !== 1'b0) begin
            n_fail++; $display("FAIL write_reg0: got %h %h busy %b want 0", b_rd1, n_rd1, b_bz1);
        end
    endtask

    task automatic test_bypass();
        RdAddr2 = 5'd7;
        wr(5'd7, 32'h1111);
        step();
        wr(5'd7, 32'h1234);
        #1;
        n_checks++;
        if (b_rd2 !== 32'h1234) begin n_fail++; $display("FAIL bypass_on: got %h want 00001234", b_rd2); end
        n_checks++;
        if (n_rd2 !== 32'h1111) begin n_fail++; $display("FAIL bypass_off_old: got %h want 00001111", n_rd2); end
        step();
        #1;
        n_checks++;
        if (n_rd2 !== 32'h1234) begin n_fail++; $display("FAIL bypass_off_next: got %h want 00001234", n_rd2); end
    endtask

    task automatic test_overflow();
        RdAddr1 = 5'd9; RdAddr2 = 5'd30;
        issue(5'd9); wr(5'd9, 32'h5);
        step();
        issue(5'd9);
        step();
        issue(5'd9);
        step();
        wr(5'd9, 32'hFFFF); OFWrEn = 1'b1; OFFlag = 1'b1;
        #1;
        n_checks++;
        if (b_rd1 !== 32'h5 || b_bz1 !== 1'b1) begin
            n_fail++; $display("FAIL of_suppress_bypass: got %h busy %b want 00000005 busy 1", b_rd1, b_bz1);
        end
        n_checks++;
        if (b_rd2 !== 32'h1 || n_rd2 !== 32'h0) begin
            n_fail++; $display("FAIL of_flag_bypass: byp %h nob %h want 1 0", b_rd2, n_rd2);
        end
        step();
        #1;
        n_checks++;
        if (n_rd1 !== 32'h5 || n_rd2 !== 32'h1 || n_bz1 !== 1'b1) begin
            n_fail++; $display("FAIL of_set: reg9 %h reg30 %h busy %b want 5 1 1", n_rd1, n_rd2, n_bz1);
        end
        wr(5'd9, 32'hFFFF); OFWrEn = 1'b1; OFFlag = 1'b0;
        step();
        #1;
        n_checks++;
        if (n_rd1 !== 32'hFFFF || n_rd2 !== 32'h0 || n_bz1 !== 1'b0 || b_rd1 !== 32'hFFFF) begin
            n_fail++; $display("FAIL of_clear: reg9 %h reg30 %h busy %b want ffff 0 0", n_rd1, n_rd2, n_bz1);
        end
    endtask

    task automatic test_flag_collision();
        RdAddr1 = 5'd30;
        wr(5'd30, 32'h12345670);
        step();
        wr(5'd30, 32'hAAAAAAAA); OFWrEn = 1'b1; OFFlag = 1'b1;
        #1;
        n_checks++;
        if (b_rd1 !== 32'h12345671) begin n_fail++; $display("FAIL flag_coll_bypass: got %h want 12345671", b_rd1); end
        step();
        #1;
        n_checks++;
        if (n_rd1 !== 32'h12345671 || b_rd1 !== 32'h12345671) begin
            n_fail++; $display("FAIL flag_coll_suppressed: got %h %h want 12345671", n_rd1, b_rd1);
        end
        wr(5'd30, 32'hAAAAAAAA); OFWrEn = 1'b1; OFFlag = 1'b0;
        step();
        #1;
        n_checks++;
        if (n_rd1 !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL flag_coll_written: got %h want aaaaaaaa", n_rd1); end
        wr(5'd30, 32'h0000000F); OFWrEn = 1'b1; OFFlag = 1'b0;
        #1;
        n_checks++;
        if (b_rd1 !== 32'h0000000E) begin n_fail++; $display("FAIL flag_coll_bit0_bypass: got %h want 0000000e", b_rd1); end
        step();
        #1;
        n_checks++;
        if (n_rd1 !== 32'h0000000E) begin n_fail++; $display("FAIL flag_coll_bit0: got %h want 0000000e", n_rd1); end
    endtask

    initial begin
        rst = 1'b1;
        RdAddr1 = '0; RdAddr2 = '0;
        idle();
        @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_scoreboard();
        test_simultaneous();
        test_sberr();
        test_write();
        test_bypass();
        test_overflow();
        test_flag_collision();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
